// File: rtl/wr_data_packer_if.sv
// Handshake bundle for wr_data_packer: element stream in, packed word stream out.
// The packer takes the slave modport and the producer/consumer side takes master.
interface wr_data_packer_if #(
    parameter int IN_W  = 8,
    parameter int LANES = 4
);
    localparam int OUT_W = IN_W * LANES;
    localparam int CW    = $clog2(LANES + 1);

    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [LANES-1:0] out_keep;
    logic             out_last;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, count
    );
endinterface

// File: rtl/wr_data_packer.sv
// Packs a stream of IN_W-bit elements into LANES-wide words with a keep mask,
// flushing partial words on in_last and holding one registered output word.
module wr_data_packer #(
    parameter int              IN_W      = 8,
    parameter int              LANES     = 4,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [IN_W-1:0] PAD_VAL   = '0
) (
    input logic             clk,
    input logic             rstn,
    input logic             clr,
    wr_data_packer_if.slave bus
);
    localparam int OUT_W = IN_W * LANES;
    localparam int CW    = $clog2(LANES + 1);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] word;
    logic [LANES-1:0] keep;
    logic [CW-1:0]    count;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [LANES-1:0] out_keep;
    logic             out_last;
    logic             in_ready;
    logic             accept;
    logic             complete;

    function automatic int lane_lo(input int k);
        return MSB_FIRST ? (OUT_W - (k + 1) * IN_W) : (k * IN_W);
    endfunction

    assign in_ready = !clr && !(out_valid && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && (bus.in_last || (count == CW'(LANES - 1)));

    // Lanes below count come from the accumulator, lane count is the element
    // arriving now, and everything above is padding.
    always_comb begin
        word = '0;
        keep = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(count)) begin
                word[lane_lo(k) +: IN_W] = acc[lane_lo(k) +: IN_W];
                keep[k] = 1'b1;
            end else if (k == int'(count)) begin
                word[lane_lo(k) +: IN_W] = bus.in_data;
                keep[k] = 1'b1;
            end else begin
                word[lane_lo(k) +: IN_W] = PAD_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            count     <= '0;
            out_valid <= 1'b0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (complete) begin
                out_data  <= word;
                out_keep  <= keep;
                out_last  <= bus.in_last;
                out_valid <= 1'b1;
                count     <= '0;
            end else begin
                if (out_valid && bus.out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    acc[lane_lo(int'(count)) +: IN_W] <= bus.in_data;
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_keep  = out_keep;
    assign bus.out_last  = out_last;
    assign bus.count     = count;
endmodule

// File: tb/tb_wr_data_packer.sv
// Directed bench for wr_data_packer: an MSB-first default instance and an
// LSB-first 0xFF-padded instance share the same stimulus.
module tb_wr_data_packer;
    logic clk = 1'b0;
    logic rstn;
    logic clr;
    int   test_count = 0;
    int   fail_count = 0;

    always #5 clk = ~clk;

    wr_data_packer_if #(.IN_W(8), .LANES(4)) bus_a ();
    wr_data_packer_if #(.IN_W(8), .LANES(4)) bus_b ();

    wr_data_packer dut_a (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus_a.slave)
    );

    wr_data_packer #(.IN_W(8), .LANES(4), .MSB_FIRST(1'b0), .PAD_VAL(8'hFF)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus_b.slave)
    );

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.in_last   = bus_a.in_last;
    assign bus_b.out_ready = bus_a.out_ready;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last);
        bus_a.in_valid = valid;
        bus_a.in_data  = data;
        bus_a.in_last  = last;
        @(posedge clk);
        #1;
    endtask

    // Presents one element, confirms the packer is ready for it, then clocks it in.
    task automatic pushElem(input string tag, input logic [7:0] data, input logic last);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = data;
        bus_a.in_last  = last;
        #1;
        checkOutput({tag, " in_ready"}, 64'(bus_a.in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkWord(input string tag, input logic [31:0] data, input logic [3:0] keep, input logic last);
        checkOutput({tag, " out_valid"}, 64'(bus_a.out_valid), 64'd1);
        checkOutput({tag, " out_data"},  64'(bus_a.out_data),  64'(data));
        checkOutput({tag, " out_keep"},  64'(bus_a.out_keep),  64'(keep));
        checkOutput({tag, " out_last"},  64'(bus_a.out_last),  64'(last));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        clr  = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.in_last   = 1'b0;
        bus_a.out_ready = 1'b1;
        #3;
        checkOutput("reset out_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("reset out_data",  64'(bus_a.out_data),  64'd0);
        checkOutput("reset out_keep",  64'(bus_a.out_keep),  64'd0);
        checkOutput("reset out_last",  64'(bus_a.out_last),  64'd0);
        checkOutput("reset count",     64'(bus_a.count),     64'd0);
        checkOutput("reset in_ready",  64'(bus_a.in_ready),  64'd1);
        #9 rstn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Full word
        pushElem("full e0", 8'h11, 1'b0);
        checkOutput("full count1", 64'(bus_a.count), 64'd1);
        checkOutput("full no early valid", 64'(bus_a.out_valid), 64'd0);
        pushElem("full e1", 8'h22, 1'b0);
        pushElem("full e2", 8'h33, 1'b0);
        checkOutput("full count3", 64'(bus_a.count), 64'd3);
        pushElem("full e3", 8'h44, 1'b0);
        checkWord("full", 32'h11223344, 4'b1111, 1'b0);
        checkOutput("full count0", 64'(bus_a.count), 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("full one-cycle valid", 64'(bus_a.out_valid), 64'd0);

        // Partial flush and lane order on both instances
        pushElem("part e0", 8'hAA, 1'b0);
        pushElem("part e1", 8'hBB, 1'b1);
        checkWord("part", 32'hAABB0000, 4'b0011, 1'b1);
        checkOutput("part lsb out_data", 64'(bus_b.out_data), 64'hFFFFBBAA);
        checkOutput("part lsb out_keep", 64'(bus_b.out_keep), 64'b0011);
        checkOutput("part lsb out_last", 64'(bus_b.out_last), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Single-element last
        pushElem("single", 8'h5C, 1'b1);
        checkWord("single", 32'h5C000000, 4'b0001, 1'b1);
        checkOutput("single lsb out_data", 64'(bus_b.out_data), 64'hFFFFFF5C);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("single drained", 64'(bus_a.out_valid), 64'd0);

        // Last on the final lane gives a full word flagged last
        pushElem("lastfull e0", 8'h41, 1'b0);
        pushElem("lastfull e1", 8'h42, 1'b0);
        pushElem("lastfull e2", 8'h43, 1'b0);
        pushElem("lastfull e3", 8'h44, 1'b1);
        checkWord("lastfull", 32'h41424344, 4'b1111, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Backpressure: word held, input stalled, in_last while stalled ignored
        bus_a.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) pushElem("bp fill", 8'(i), 1'b0);
        checkWord("bp first", 32'h01020304, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = 8'h05;
            bus_a.in_last  = (c == 0);
            #1;
            checkOutput("bp in_ready low", 64'(bus_a.in_ready), 64'd0);
            @(posedge clk);
            #1;
            checkWord("bp hold", 32'h01020304, 4'b1111, 1'b0);
            checkOutput("bp count held", 64'(bus_a.count), 64'd0);
        end
        bus_a.out_ready = 1'b1;
        pushElem("bp e5", 8'h05, 1'b0);
        checkOutput("bp drained", 64'(bus_a.out_valid), 64'd0);
        checkOutput("bp count1", 64'(bus_a.count), 64'd1);
        pushElem("bp e6", 8'h06, 1'b0);
        pushElem("bp e7", 8'h07, 1'b0);
        pushElem("bp e8", 8'h08, 1'b0);
        checkWord("bp second", 32'h05060708, 4'b1111, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Streaming: 12 back-to-back elements, a word every 4th cycle
        for (int i = 0; i < 12; i++) begin
            pushElem("stream", 8'(i), 1'b0);
            if (i % 4 == 3)
                checkWord("stream word", {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)}, 4'b1111, 1'b0);
            else
                checkOutput("stream gap", 64'(bus_a.out_valid), 64'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Clear drops the partial word and blocks the element offered with it
        pushElem("clr e0", 8'h10, 1'b0);
        pushElem("clr e1", 8'h20, 1'b0);
        clr = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h99;
        #1;
        checkOutput("clr in_ready", 64'(bus_a.in_ready), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr count", 64'(bus_a.count), 64'd0);
        checkOutput("clr out_valid", 64'(bus_a.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) pushElem("after clr", 8'(8'h30 + i), 1'b0);
        checkWord("after clr", 32'h30313233, 4'b1111, 1'b0);

        // Asynchronous reset with an output word pending
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checkOutput("async rst out_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("async rst count",     64'(bus_a.count),     64'd0);
        checkOutput("async rst out_keep",  64'(bus_a.out_keep),  64'd0);
        checkOutput("async rst out_data",  64'(bus_a.out_data),  64'd0);
        #3 rstn = 1'b1;
        bus_a.out_ready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post rst idle", 64'(bus_a.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
